// File: rtl/su_adder_sched.sv
// Sequencer for the spatial-unrolled psum adder: drains each used psum RF entry through the adder.
// Optional build macro SU_SCHED_PERF_EN adds busy/stall cycle counters (perf_busy_cyc, perf_stall_cyc).
module su_adder_sched #(
    parameter int ROW                   = 16,
    parameter int PSUM_RF_ADDR_BITWIDTH = 2,
    parameter int BRAM_ADDR_BITWIDTH    = 10,
    parameter int BRAM_STRIDE           = 1,
    parameter int TIMEOUT_CYC           = 1024
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [4:0]                         cfg_irrel_num,
    input  logic [PSUM_RF_ADDR_BITWIDTH:0]     cfg_psum_num,
    input  logic [BRAM_ADDR_BITWIDTH-1:0]      cfg_bram_base,
    input  logic                               pe_psum_finish,
    input  logic                               conv_finish,
    output logic                               pe_psum_ack,
    output logic                               add_start,
    output logic [4:0]                         irrel_num,
    output logic [PSUM_RF_ADDR_BITWIDTH-1:0]   psum_rf_addr,
    output logic [BRAM_ADDR_BITWIDTH-1:0]      bram_base,
    input  logic                               su_add_finish,
    output logic                               busy,
    output logic                               done,
    output logic                               err
`ifdef SU_SCHED_PERF_EN
    ,
    output logic [31:0]                        perf_busy_cyc,
    output logic [31:0]                        perf_stall_cyc
`endif
);

    localparam int W  = PSUM_RF_ADDR_BITWIDTH;
    localparam int PW = W + 1;
    localparam int BA = BRAM_ADDR_BITWIDTH;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] PSUM_MAX = PW'(1 << W);
    localparam logic [5:0]    ROW_MAX  = 6'(ROW);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [BA-1:0] STRIDE   = BA'(BRAM_STRIDE);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_PSUM = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_ADD  = 3'd3,
        S_DRAIN     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [4:0]       irrel_r;
    logic [PW-1:0]    psum_num_r;
    logic [PW-1:0]    cnt_r;
    logic [BA-1:0]    bram_base_r;
    logic [TW-1:0]    tmo_cnt_r;
    logic             last_pass_r;
    logic             err_r;
    logic             cfg_ready_r;
    logic             busy_r;
    logic             add_start_r;
    logic             ack_r;
    logic             done_r;
    logic             cfg_ready_s;
    logic             busy_s;
    logic             add_start_s;
    logic             ack_s;
    logic             done_s;
    logic             cfg_acc_s;
    logic             legal_s;
    logic             last_entry_s;
    logic             tmo_hit_s;

    function automatic logic cfg_is_legal(input logic [4:0] irrel, input logic [PW-1:0] pnum);
        logic ok_irrel;
        logic ok_pnum;
        ok_irrel = (irrel != 5'd0) && ({1'b0, irrel} <= ROW_MAX);
        ok_pnum  = (pnum != {PW{1'b0}}) && (pnum <= PSUM_MAX);
        return ok_irrel && ok_pnum;
    endfunction

    assign cfg_acc_s    = cfg_valid & cfg_ready_r;
    assign legal_s      = cfg_is_legal(cfg_irrel_num, cfg_psum_num);
    assign last_entry_s = (cnt_r == (psum_num_r - {{(PW-1){1'b0}}, 1'b1}));
    // Finish wins over timeout when both land in the same cycle.
    assign tmo_hit_s    = (state_r == S_WAIT_ADD) & ~su_add_finish & (tmo_cnt_r == TMO_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:      state_s = (cfg_acc_s && legal_s) ? S_WAIT_PSUM : S_IDLE;
            S_WAIT_PSUM: state_s = pe_psum_finish ? S_ISSUE : S_WAIT_PSUM;
            S_ISSUE:     state_s = S_WAIT_ADD;
            S_WAIT_ADD: begin
                if (su_add_finish) begin
                    state_s = last_entry_s ? S_DRAIN : S_ISSUE;
                end else if (tmo_hit_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_WAIT_ADD;
                end
            end
            S_DRAIN:     state_s = last_pass_r ? S_DONE : S_WAIT_PSUM;
            S_DONE:      state_s = S_IDLE;
            default:     state_s = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        cfg_ready_s = 1'b0;
        busy_s      = 1'b1;
        add_start_s = 1'b0;
        ack_s       = 1'b0;
        done_s      = 1'b0;
        case (state_s)
            S_IDLE: begin
                cfg_ready_s = 1'b1;
                busy_s      = 1'b0;
            end
            S_ISSUE:     add_start_s = 1'b1;
            S_DRAIN:     ack_s       = 1'b1;
            S_DONE:      done_s      = 1'b1;
            S_WAIT_PSUM: busy_s      = 1'b1;
            S_WAIT_ADD:  busy_s      = 1'b1;
            default: begin
                cfg_ready_s = 1'b1;
                busy_s      = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            add_start_r <= 1'b0;
            ack_r       <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cfg_ready_r <= cfg_ready_s;
            busy_r      <= busy_s;
            add_start_r <= add_start_s;
            ack_r       <= ack_s;
            done_r      <= done_s;
        end
    end

    // Config latch, entry/BRAM walk, timeout and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irrel_r     <= 5'd0;
            psum_num_r  <= {PW{1'b0}};
            cnt_r       <= {PW{1'b0}};
            bram_base_r <= {BA{1'b0}};
            tmo_cnt_r   <= {TW{1'b0}};
            last_pass_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cfg_acc_s && legal_s) begin
                        irrel_r     <= cfg_irrel_num;
                        psum_num_r  <= cfg_psum_num;
                        bram_base_r <= cfg_bram_base;
                        cnt_r       <= {PW{1'b0}};
                        err_r       <= 1'b0;
                    end else if (cfg_acc_s) begin
                        err_r       <= 1'b1;
                    end
                end
                S_WAIT_PSUM: begin
                    if (pe_psum_finish) begin
                        last_pass_r <= conv_finish;
                    end
                end
                S_ISSUE: tmo_cnt_r <= {TW{1'b0}};
                S_WAIT_ADD: begin
                    if (su_add_finish) begin
                        bram_base_r <= bram_base_r + STRIDE;
                        cnt_r       <= cnt_r + {{(PW-1){1'b0}}, 1'b1};
                    end else if (tmo_hit_s) begin
                        err_r       <= 1'b1;
                        cnt_r       <= {PW{1'b0}};
                    end else begin
                        tmo_cnt_r   <= tmo_cnt_r + TW'(1);
                    end
                end
                S_DRAIN: cnt_r <= {PW{1'b0}};
                default: cnt_r <= cnt_r;
            endcase
        end
    end

`ifdef SU_SCHED_PERF_EN
    logic [31:0] perf_busy_r;
    logic [31:0] perf_stall_r;

    // Saturating busy/stall cycle counters, cleared by any accepted config.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_busy_r  <= 32'd0;
            perf_stall_r <= 32'd0;
        end else if (cfg_acc_s) begin
            perf_busy_r  <= 32'd0;
            perf_stall_r <= 32'd0;
        end else begin
            if (busy_r && (perf_busy_r != 32'hFFFF_FFFF)) begin
                perf_busy_r <= perf_busy_r + 32'd1;
            end
            if ((state_r == S_WAIT_ADD) && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
        end
    end

    assign perf_busy_cyc  = perf_busy_r;
    assign perf_stall_cyc = perf_stall_r;
`endif

    assign cfg_ready    = cfg_ready_r;
    assign busy         = busy_r;
    assign add_start    = add_start_r;
    assign pe_psum_ack  = ack_r;
    assign done         = done_r;
    assign err          = err_r;
    assign irrel_num    = irrel_r;
    assign psum_rf_addr = cnt_r[W-1:0];
    assign bram_base    = bram_base_r;

endmodule
